// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;
  localparam logic [31:0] PC_INC           = 32'd4;

  typedef enum logic {StBoot, StRun} state_e;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_if.sv
// ROM, redirect and decode-side handshake signals of the fetch stage.
interface fetch_if #(
  parameter int unsigned ROM_AW = 6
) ();

  logic              rom_en;
  logic [ROM_AW-1:0] rom_addr;
  logic [31:0]       rom_data;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic              ins_valid;
  logic              ins_ready;
  logic [31:0]       ins;
  logic [31:0]       ins_pc;

  modport master (
    output rom_en, rom_addr, ins_valid, ins, ins_pc,
    input  rom_data, redirect_valid, redirect_pc, ins_ready
  );

  modport slave (
    input  rom_en, rom_addr, ins_valid, ins, ins_pc,
    output rom_data, redirect_valid, redirect_pc, ins_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// Show-ahead prefetch FIFO holding {pc, ins}; clear wins over push and pop.
module fetch_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [W-1:0]           wdata,
  input  logic                   pop,
  input  logic                   clear,
  output logic [W-1:0]           rdata,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  always_comb begin
    do_pop  = pop && (count_q != '0) && !clear;
    do_push = push && !clear && ((count_q != FULL) || do_pop);
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (!do_push && do_pop) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      if (clear) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (do_push) begin
          mem_q[wr_ptr_q] <= wdata;
          wr_ptr_q        <= wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
          rd_ptr_q <= rd_ptr_q + 1'b1;
        end
      end
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC sequencing, ROM request issue with credit check, redirect flush.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int unsigned ROM_AW     = 6,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input logic      clk,
  input logic      rst,
  fetch_if.master  bus
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        inflight_q;
  logic        run, redir, pop, issue, push, ins_valid;
  logic [CW:0] occ;
  logic [63:0] head;
  logic [CW-1:0] fifo_count;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StBoot:  state_d = StRun;
      StRun:   state_d = StRun;
      default: state_d = StBoot;
    endcase
  end

  // Credit: entries present plus the one returning must leave room for a new request.
  always_comb begin
    run       = (state_q == StRun);
    redir     = run && bus.redirect_valid;
    ins_valid = (fifo_count != '0);
    pop       = ins_valid && bus.ins_ready;
    occ       = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, pop};
    issue     = run && !bus.redirect_valid && (occ < (CW + 1)'(FIFO_DEPTH));
    push      = inflight_q && !redir;
    req_pc_d  = issue ? fetch_pc_q : req_pc_q;
    fetch_pc_d = fetch_pc_q;
    if (redir) begin
      fetch_pc_d = align_pc(bus.redirect_pc);
    end else if (issue) begin
      fetch_pc_d = fetch_pc_q + PC_INC;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StBoot;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= issue;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (64)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata ({req_pc_q, bus.rom_data}),
    .pop   (pop),
    .clear (redir),
    .rdata (head),
    .count (fifo_count)
  );

  assign bus.rom_en    = issue;
  assign bus.rom_addr  = fetch_pc_q[ROM_AW+1:2];
  assign bus.ins_valid = ins_valid;
  assign bus.ins       = ins_valid ? head[31:0]  : 32'h0;
  assign bus.ins_pc    = ins_valid ? head[63:32] : 32'h0;

endmodule
